// File: rtl/dr_phase_seq.sv
// Purpose : phase sequencer for a dual-rail (NCL-style) pipeline stage: alternates data/spacer waves and captures results.
// Latency : start_req -> start_ack/spacer low next cycle; data complete -> cap_en next cycle; all outputs registered.
// Backpr. : HOLD keeps res_valid high until res_ready is sampled; start_req is only accepted in IDLE or on spacer completion.
//
// Ports   : clk, reset (sync, active high)
//           start_req/start_ack      token request and one-cycle acknowledge
//           cd_data/cd_spacer [N_CD] per-group completion detect (data complete / spacer complete)
//           spacer                   SP control of the dual-rail registers (1 = load spacer)
//           cap_en                   one-cycle capture strobe to the output registers
//           res_valid/res_ready      result handshake
//           busy, token_cnt[7:0]     status; token_cnt counts completed tokens and wraps
//           err/err_clr              sticky watchdog error and its clear
// Option  : define DR_PHASE_TIMEOUT_EN to add the DATA/SPACER watchdog (TIMEOUT_CYCLES) and the ERR state.
//           Without it err is tied 0, err_clr is unused and DATA/SPACER wait forever.
module dr_phase_seq #(
   parameter int N_CD           = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_req,
   output logic            start_ack,
   input  logic [N_CD-1:0] cd_data,
   input  logic [N_CD-1:0] cd_spacer,
   output logic            spacer,
   output logic            cap_en,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            busy,
   output logic [7:0]      token_cnt,
   output logic            err,
   input  logic            err_clr
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DATA    = 3'd1,
      S_CAPTURE = 3'd2,
      S_HOLD    = 3'd3,
      S_SPACER  = 3'd4,
      S_ERR     = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic       start_ack_q, start_ack_d;
   logic       spacer_q, spacer_d;
   logic       cap_en_q, cap_en_d;
   logic       res_valid_q, res_valid_d;
   logic       busy_q, busy_d;
   logic [7:0] token_cnt_q, token_cnt_d;

`ifdef DR_PHASE_TIMEOUT_EN
   // wd_q counts completed cycles in the current DATA/SPACER visit; the
   // last allowed cycle is TIMEOUT_CYCLES-1, so the visit lasts TIMEOUT_CYCLES.
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wd_q, wd_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      state_d     = state_q;
      start_ack_d = 1'b0;
      token_cnt_d = token_cnt_q;
`ifdef DR_PHASE_TIMEOUT_EN
      wd_d        = wd_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               state_d     = S_DATA;
               start_ack_d = 1'b1;
            end
         end
         S_DATA: begin
            if (&cd_data) state_d = S_CAPTURE;
`ifdef DR_PHASE_TIMEOUT_EN
            else if (wd_q == WD_LAST) state_d = S_ERR;
            else wd_d = wd_q + 8'd1;
`endif
         end
         S_CAPTURE: state_d = S_HOLD;
         S_HOLD: begin
            if (res_ready) begin
               state_d     = S_SPACER;
               token_cnt_d = token_cnt_q + 8'd1;
            end
         end
         S_SPACER: begin
            // Spacer wave complete: a pending request starts the next token
            // immediately instead of passing through IDLE.
            if (&cd_spacer) begin
               state_d     = start_req ? S_DATA : S_IDLE;
               start_ack_d = start_req;
            end
`ifdef DR_PHASE_TIMEOUT_EN
            else if (wd_q == WD_LAST) state_d = S_ERR;
            else wd_d = wd_q + 8'd1;
`endif
         end
         S_ERR: begin
`ifdef DR_PHASE_TIMEOUT_EN
            if (err_clr) state_d = S_IDLE;
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
`ifdef DR_PHASE_TIMEOUT_EN
      if ((state_d != state_q) && ((state_d == S_DATA) || (state_d == S_SPACER))) wd_d = '0;
      err_d       = (state_d == S_ERR);
`endif
      // Outputs are registered versions of the next state's decode.
      spacer_d    = (state_d == S_IDLE) || (state_d == S_SPACER) || (state_d == S_ERR);
      cap_en_d    = (state_d == S_CAPTURE);
      res_valid_d = (state_d == S_HOLD);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         start_ack_q <= 1'b0;
         spacer_q    <= 1'b1;
         cap_en_q    <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         token_cnt_q <= 8'd0;
`ifdef DR_PHASE_TIMEOUT_EN
         wd_q        <= 8'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         start_ack_q <= start_ack_d;
         spacer_q    <= spacer_d;
         cap_en_q    <= cap_en_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         token_cnt_q <= token_cnt_d;
`ifdef DR_PHASE_TIMEOUT_EN
         wd_q        <= wd_d;
         err_q       <= err_d;
`endif
      end
   end

   assign start_ack = start_ack_q;
   assign spacer    = spacer_q;
   assign cap_en    = cap_en_q;
   assign res_valid = res_valid_q;
   assign busy      = busy_q;
   assign token_cnt = token_cnt_q;

`ifdef DR_PHASE_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
   logic       unused_err_clr;
   logic [7:0] unused_timeout;
   assign unused_err_clr = err_clr;
   assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_dr_phase_seq.sv
// Purpose : self-checking bench for dr_phase_seq: directed scenarios, throughput/wrap run, randomized run.
// Latency : outputs compared every cycle at the falling edge against a phase-level reference model.
// Backpr. : n/a (bench drives res_ready directly).
module tb_dr_phase_seq;
   localparam int NCD = 4;
   localparam int TMO = 16;
`ifdef DR_PHASE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset, start_req, start_ack, spacer, cap_en, res_valid, res_ready, busy, err, err_clr;
   logic [NCD-1:0] cd_data, cd_spacer;
   logic [7:0]     token_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   bit env_auto = 1'b0;
   bit sp_prev = 1'b1;

   always #5 clk = ~clk;

   dr_phase_seq #(.N_CD(NCD), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .start_req(start_req), .start_ack(start_ack),
      .cd_data(cd_data), .cd_spacer(cd_spacer), .spacer(spacer), .cap_en(cap_en),
      .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .token_cnt(token_cnt),
      .err(err), .err_clr(err_clr)
   );

   // ---------------- reference model: token phases and dwell time ----------------
   localparam int P_IDLE = 0, P_DATA = 1, P_CAP = 2, P_HOLD = 3, P_SPC = 4, P_ERR = 5;
   int ph = P_IDLE;
   int m_tok = 0;
   int m_dwell = 0;
   bit m_ack = 1'b0;

   always @(posedge clk) begin
      int nxt;
      bit ack;
      nxt = ph;
      ack = 1'b0;
      if (reset) begin
         ph = P_IDLE; m_tok = 0; m_dwell = 0; m_ack = 1'b0;
      end else begin
         case (ph)
            P_IDLE: if (start_req) begin nxt = P_DATA; ack = 1'b1; end
            P_DATA: begin
               if (cd_data == {NCD{1'b1}}) nxt = P_CAP;
               else if (TO_EN && (m_dwell + 1 >= TMO)) nxt = P_ERR;
            end
            P_CAP:  nxt = P_HOLD;
            P_HOLD: if (res_ready) begin nxt = P_SPC; m_tok = (m_tok + 1) % 256; end
            P_SPC: begin
               if (cd_spacer == {NCD{1'b1}}) begin nxt = start_req ? P_DATA : P_IDLE; ack = start_req; end
               else if (TO_EN && (m_dwell + 1 >= TMO)) nxt = P_ERR;
            end
            default: if (err_clr) nxt = P_IDLE;
         endcase
         m_dwell = (nxt == ph) ? m_dwell + 1 : 0;
         ph = nxt;
         m_ack = ack;
      end
   end

   // Single compare process: all outputs, every cycle once reset has been applied.
   always @(negedge clk) begin
      logic [13:0] act, exp;
      if (chk_en) begin
         act = {start_ack, spacer, cap_en, res_valid, busy, err, token_cnt};
         exp = {m_ack, (ph == P_IDLE) || (ph == P_SPC) || (ph == P_ERR), ph == P_CAP, ph == P_HOLD,
                ph != P_IDLE, ph == P_ERR, 8'(m_tok)};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t {ack,sp,cap,rv,busy,err,cnt} actual=%h required=%h", $time, act, exp);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Auto environment: rails reset to spacer within the cycle, while a data
   // wave needs one full cycle of spacer=0 to propagate through the logic.
   task automatic tick();
      @(posedge clk);
      #1;
      if (env_auto) begin
         cd_spacer = spacer ? '1 : '0;
         cd_data   = (!spacer && !sp_prev) ? '1 : '0;
         sp_prev   = spacer;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; start_req = 1'b0; res_ready = 1'b0; err_clr = 1'b0; cd_data = '0; cd_spacer = '0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int acks, last, bad, cyc;
      bit wrap;
      logic [7:0] prev_tok;

      do_reset();
      chk_en = 1'b1;
      chk("rst_spacer", spacer, 1); chk("rst_busy", busy, 0); chk("rst_token_cnt", token_cnt, 0);
      chk("rst_start_ack", start_ack, 0); chk("rst_cap_en", cap_en, 0); chk("rst_res_valid", res_valid, 0);
      chk("rst_err", err, 0);

      // Basic token with explicit completion inputs
      tick(); chk("idle_stays", busy, 0);
      start_req = 1'b1; tick(); start_req = 1'b0;
      chk("t1_ack", start_ack, 1); chk("t1_spacer_low", spacer, 0); chk("t1_busy", busy, 1);
      tick(); chk("t1_ack_one_cycle", start_ack, 0);
      tick(); cd_data = 4'hF;
      tick(); cd_data = 4'h0; chk("t1_cap_en", cap_en, 1); chk("t1_rv_not_yet", res_valid, 0);
      tick(); chk("t1_cap_one_cycle", cap_en, 0); chk("t1_res_valid", res_valid, 1); chk("t1_hold_spacer", spacer, 0);
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      chk("t1_rv_drop", res_valid, 0); chk("t1_spacer_high", spacer, 1); chk("t1_token_cnt", token_cnt, 1);
      cd_spacer = 4'hF; tick(); cd_spacer = 4'h0;
      chk("t1_back_idle", busy, 0);

      // Partial data completion must not capture
      start_req = 1'b1; tick(); start_req = 1'b0;
      cd_data = 4'h7;
      for (int i = 0; i < 5; i++) begin tick(); chk("partial_no_cap", cap_en, 0); end
      cd_data = 4'hF; tick(); cd_data = 4'h0;
      chk("full_cap", cap_en, 1);
      tick(); chk("hold_entry", res_valid, 1);

      // Long HOLD: no watchdog, start_req ignored
      start_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(); chk("hold_valid", res_valid, 1); chk("hold_no_ack", start_ack, 0); chk("hold_no_err", err, 0);
      end
      start_req = 1'b0;
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      chk("hold_token_cnt", token_cnt, 2);
      cd_spacer = 4'hF; tick(); cd_spacer = 4'h0;
      chk("hold_back_idle", busy, 0);

      // Reset in HOLD wins over res_ready/start_req
      start_req = 1'b1; tick(); start_req = 1'b0;
      cd_data = 4'hF; tick(); cd_data = 4'h0;
      tick(); chk("rsthold_valid", res_valid, 1);
      reset = 1'b1; res_ready = 1'b1; start_req = 1'b1;
      tick();
      reset = 1'b0; res_ready = 1'b0; start_req = 1'b0;
      chk("rsthold_rv", res_valid, 0); chk("rsthold_spacer", spacer, 1); chk("rsthold_cnt", token_cnt, 0);
      chk("rsthold_busy", busy, 0); chk("rsthold_ack", start_ack, 0);

      // DATA with no completion: watchdog (or indefinite wait)
      start_req = 1'b1; tick(); start_req = 1'b0;
      err_clr = 1'b1;
      for (int i = 1; i < TMO; i++) tick();
      chk("wd_cycle16_noerr", err, 0); chk("wd_cycle16_data", spacer, 0);
      tick();
`ifdef DR_PHASE_TIMEOUT_EN
      err_clr = 1'b0;
      chk("wd_err", err, 1); chk("wd_err_spacer", spacer, 1); chk("wd_err_busy", busy, 1);
      start_req = 1'b1; tick(); start_req = 1'b0;
      chk("wd_err_sticky", err, 1); chk("wd_err_no_ack", start_ack, 0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("wd_clr_err", err, 0); chk("wd_clr_idle", busy, 0);
`else
      for (int i = 0; i < 25; i++) tick();
      err_clr = 1'b0;
      chk("nowd_err", err, 0); chk("nowd_still_data", spacer, 0); chk("nowd_busy", busy, 1);
`endif

      // Throughput: back-to-back tokens, counter wrap
      do_reset();
      env_auto = 1'b1; sp_prev = 1'b1;
      start_req = 1'b1; res_ready = 1'b1;
      acks = 0; last = 0; bad = 0; cyc = 0; wrap = 1'b0; prev_tok = 8'd0;
      for (int c = 0; c < 3000 && acks < 300; c++) begin
         tick(); cyc++;
         if (token_cnt == 8'd0 && prev_tok == 8'd255) wrap = 1'b1;
         prev_tok = token_cnt;
         if (start_ack === 1'b1) begin
            acks++;
            if (acks > 1 && (cyc - last) != 5) bad++;
            last = cyc;
         end
      end
      start_req = 1'b0;
      for (int c = 0; c < 20 && busy !== 1'b0; c++) tick();
      chk("tput_acks", acks, 300); chk("tput_bad_periods", bad, 0); chk("tput_drain_idle", busy, 0);
      chk("tput_wrap_seen", wrap, 1); chk("tput_token_cnt", token_cnt, 44);
      env_auto = 1'b0; res_ready = 1'b0;

      // Randomized run with varying completion probability
      for (int blk = 0; blk < 12; blk++) begin
         int pct;
         pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 35 : 70);
         for (int c = 0; c < 250; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            start_req = $urandom_range(0, 1) == 1;
            res_ready = $urandom_range(0, 99) < 50;
            err_clr   = $urandom_range(0, 99) < 20;
            cd_data   = ($urandom_range(0, 99) < pct) ? '1 : NCD'($urandom);
            cd_spacer = ($urandom_range(0, 99) < pct) ? '1 : NCD'($urandom);
            tick();
         end
      end
      reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dr_phase_seq.md
DR_PHASE_SEQ -- requirements
Module: dr_phase_seq

Interface
REQ-001 Parameter N_CD, default 4: number of completion-detect groups monitored.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, legal range 2..255: watchdog limit in clk cycles.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_req  input  1  environment requests one data token evaluation.
REQ-006 start_ack  output  1  one-cycle acknowledge of start_req.
REQ-007 cd_data  input  N_CD  per-group completion flag: all rails of the group hold valid data.
REQ-008 cd_spacer  input  N_CD  per-group completion flag: all rails of the group are 0 (spacer).
REQ-009 spacer  output  1  drives SP of the dual-rail registers; 1 means load spacer.
REQ-010 cap_en  output  1  one-cycle capture strobe to the output registers.
REQ-011 res_valid  output  1  captured result available.
REQ-012 res_ready  input  1  consumer accepts the result.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 token_cnt  output  8  count of completed tokens.
REQ-015 err  output  1  sticky watchdog error.
REQ-016 err_clr  input  1  clears the error state.

Function
REQ-017 All outputs SHALL be registered; states: IDLE, DATA, CAPTURE, HOLD, SPACER, ERR.
REQ-018 IDLE: spacer=1; an edge sampling start_req=1 SHALL give start_ack=1, spacer=0, state DATA in the next cycle.
REQ-019 DATA: spacer=0; an edge sampling &cd_data=1 SHALL give state CAPTURE in the next cycle; cd_spacer SHALL be ignored.
REQ-020 CAPTURE: cap_en=1 for exactly one cycle; the next state SHALL be HOLD.
REQ-021 HOLD: res_valid=1 and spacer=0 until an edge samples res_ready=1; the next cycle SHALL have res_valid=0, spacer=1, state SPACER, token_cnt+1.
REQ-022 token_cnt SHALL wrap from 255 to 0.
REQ-023 SPACER: spacer=1; an edge sampling &cd_spacer=1 SHALL go to IDLE; cd_data SHALL be ignored.
REQ-024 If start_req=1 at that same edge, the block SHALL go directly to DATA with start_ack=1 (back-to-back token).
REQ-025 start_req in DATA, CAPTURE, HOLD or ERR SHALL be ignored and not acknowledged.
REQ-026 Minimum token period SHALL be 5 cycles with completion and res_ready immediate.
REQ-027 res_ready outside HOLD SHALL have no effect.

Reset
REQ-028 reset=1 at an edge SHALL, in the next cycle and from any state including mid-token, set state IDLE, spacer=1, start_ack=0, cap_en=0, res_valid=0, busy=0, token_cnt=0, err=0, and watchdog count 0.
REQ-029 reset SHALL take priority over every other input.

Configuration
REQ-030 Macro DR_PHASE_TIMEOUT_EN compiled in: a watchdog counter SHALL clear on entry to DATA or SPACER and increment each cycle spent there.
REQ-031 With the macro in, reaching TIMEOUT_CYCLES cycles in DATA or SPACER without completion SHALL enter ERR.
REQ-032 ERR: err=1, spacer=1, busy=1; an edge sampling err_clr=1 SHALL go to IDLE with err=0; err_clr elsewhere SHALL be ignored.
REQ-033 Macro absent: no watchdog counter; err SHALL be constant 0, err_clr unused, DATA/SPACER wait indefinitely.

Verification
REQ-034 Reset, then pulse start_req -> start_ack 1 cycle, spacer 0; set cd_data=4'hF two cycles later -> cap_en 1 cycle, res_valid; res_ready=1 -> spacer=1, token_cnt=1; cd_spacer=4'hF -> IDLE.
REQ-035 cd_data=4'h7 held in DATA -> no cap_en; then 4'hF -> cap_en one cycle later.
REQ-036 start_req held high throughout, res_ready tied 1, completions immediate, 300 tokens -> token period 5 cycles, token_cnt wraps 255->0 and reads 44 at the end.
REQ-037 Macro in, TIMEOUT_CYCLES=16, cd_data held 0 in DATA -> err=1 after 16 cycles, spacer=1; err_clr=1 -> IDLE, err=0.
REQ-038 reset asserted in HOLD with res_valid=1 -> next cycle res_valid=0, spacer=1, token_cnt=0, busy=0.
REQ-039 res_ready held 0 for 20 cycles in HOLD with macro in -> no error, res_valid stays 1.
